// File: rtl/fp_acc_pkg.sv
// Shared types and IEEE-754 single-precision field helpers for the stream accumulator.
package fp_acc_pkg;

    localparam int unsigned EXP_W = 8;
    localparam int unsigned MAN_W = 23;
    localparam logic [31:0] FP_ZERO = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ADD    = 2'd1,
        RESULT = 2'd2
    } acc_state_t;

    function automatic logic [EXP_W-1:0] fp_exp(input logic [31:0] x);
        return x[30:23];
    endfunction

    function automatic logic fp_is_special(input logic [31:0] x);
        return fp_exp(x) == 8'hFF;
    endfunction

endpackage

// File: rtl/Addition_Subtraction.sv
// Combinational single-precision add/subtract (truncating). add_sub_signal: 0=a+b, 1=a-b.
// Any inf/NaN operand raises exception and forces res to zero.
module Addition_Subtraction
    import fp_acc_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        add_sub_signal,
    output logic        exception,
    output logic [31:0] res
);

    logic [7:0]  ea, eb, e_big, e_small, diff;
    logic [23:0] ma, mb, m_big, m_small;
    logic        s_a, s_b, s_big;
    logic [26:0] sm_sh;
    logic [27:0] sum;
    logic [4:0]  lz;
    logic [8:0]  e_tmp;
    logic [22:0] frac;

    always_comb begin
        exception = fp_is_special(a) | fp_is_special(b);
        ea = fp_exp(a);
        eb = fp_exp(b);
        ma = {|ea, a[22:0]};
        mb = {|eb, b[22:0]};
        s_a = a[31];
        s_b = b[31] ^ add_sub_signal;

        // Larger magnitude operand sets the result sign and exponent
        if ({ea, ma} >= {eb, mb}) begin
            e_big = ea; m_big = ma; s_big = s_a;
            e_small = eb; m_small = mb;
        end else begin
            e_big = eb; m_big = mb; s_big = s_b;
            e_small = ea; m_small = ma;
        end

        diff  = e_big - e_small;
        sm_sh = (diff > 8'd26) ? 27'd0 : ({m_small, 3'b000} >> diff);
        if (s_a ^ s_b)
            sum = {1'b0, m_big, 3'b000} - {1'b0, sm_sh};
        else
            sum = {1'b0, m_big, 3'b000} + {1'b0, sm_sh};

        lz = 5'd27;
        for (int i = 0; i <= 26; i++) begin
            if (sum[i]) lz = 5'(26 - i);
        end

        if (sum[27]) begin
            frac  = 23'(sum >> 4);
            e_tmp = {1'b0, e_big} + 9'd1;
        end else begin
            frac  = 23'((sum << lz) >> 3);
            e_tmp = {1'b0, e_big} - 9'(lz);
        end

        if (exception || sum == 28'd0 || e_tmp[8] || e_tmp == 9'd0)
            res = FP_ZERO;
        else if (e_tmp >= 9'd255)
            res = {s_big, 8'hFF, 23'd0};
        else
            res = {s_big, e_tmp[7:0], frac};
    end

endmodule

// File: rtl/fp_stream_accumulator.sv
// Framed valid/ready FP32 accumulator around Addition_Subtraction; one beat per two cycles.
// FPACC_EXC_HOLD_EN: when defined, a beat raising an adder exception leaves the sum unchanged.
module fp_stream_accumulator
    import fp_acc_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [31:0]      s_data,
    input  logic             s_sub,
    input  logic             s_last,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [31:0]      m_data,
    output logic             m_exc,
    output logic [CNT_W-1:0] m_count
);

    acc_state_t       state_q, state_d;
    logic [31:0]      acc_q, acc_d, op_q, op_d, md_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, mc_d;
    logic             exc_q, exc_d, sub_q, sub_d, last_q, last_d;
    logic             rdy_q, rdy_d, mv_d, me_d;
    logic             add_exc;
    logic [31:0]      add_res;

    Addition_Subtraction u_add (
        .a              (acc_q),
        .b              (op_q),
        .add_sub_signal (sub_q),
        .exception      (add_exc),
        .res            (add_res)
    );

    // Soft clear must block the beat presented in the same cycle
    assign s_ready = rdy_q & ~clr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= FP_ZERO;
            cnt_q   <= '0;
            exc_q   <= 1'b0;
            op_q    <= FP_ZERO;
            sub_q   <= 1'b0;
            last_q  <= 1'b0;
            rdy_q   <= 1'b0;
            m_valid <= 1'b0;
            m_data  <= FP_ZERO;
            m_exc   <= 1'b0;
            m_count <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            exc_q   <= exc_d;
            op_q    <= op_d;
            sub_q   <= sub_d;
            last_q  <= last_d;
            rdy_q   <= rdy_d;
            m_valid <= mv_d;
            m_data  <= md_d;
            m_exc   <= me_d;
            m_count <= mc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        exc_d   = exc_q;
        op_d    = op_q;
        sub_d   = sub_q;
        last_d  = last_q;
        mv_d    = m_valid;
        md_d    = m_data;
        me_d    = m_exc;
        mc_d    = m_count;

        case (state_q)
            IDLE: begin
                if (s_valid && s_ready) begin
                    op_d    = s_data;
                    sub_d   = s_sub;
                    last_d  = s_last;
                    state_d = ADD;
                end
            end
            ADD: begin
`ifdef FPACC_EXC_HOLD_EN
                acc_d = add_exc ? acc_q : add_res;
`else
                acc_d = add_res;
`endif
                exc_d = exc_q | add_exc;
                cnt_d = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
                if (last_q) begin
                    state_d = RESULT;
                    mv_d    = 1'b1;
                    md_d    = acc_d;
                    me_d    = exc_d;
                    mc_d    = cnt_d;
                end else begin
                    state_d = IDLE;
                end
            end
            RESULT: begin
                if (m_ready) begin
                    acc_d   = FP_ZERO;
                    cnt_d   = '0;
                    exc_d   = 1'b0;
                    mv_d    = 1'b0;
                    md_d    = FP_ZERO;
                    me_d    = 1'b0;
                    mc_d    = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (clr) begin
            state_d = IDLE;
            acc_d   = FP_ZERO;
            cnt_d   = '0;
            exc_d   = 1'b0;
            mv_d    = 1'b0;
            md_d    = FP_ZERO;
            me_d    = 1'b0;
            mc_d    = '0;
        end

        rdy_d = (state_d == IDLE);
    end

endmodule
